// File: rtl/sar_pkg.sv
// Shared SAR definitions: TX state encoding and the conversion result width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sar_pkg;

    // Result width produced by the SAR controller.
    localparam int SAR_DATA_W = 8;

    // UART transmitter states.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sar_sample_fifo.sv
// Circular sample buffer between the SAR result strobe and the UART transmitter.
// Latency: a pushed word is visible on dout and counted in level one cycle after the push edge.
// Backpressure: a push into a full buffer is refused unless a pop happens in the same cycle.
module sar_sample_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Head of queue is read combinationally so the consumer can load it on the pop edge.
    assign dout = mem[rd_ptr];

    // Storage write; no reset needed since level gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sar_sample_uart_tx.sv
// Buffers SAR conversion results and streams them off-chip as 8N1 UART frames.
// Latency: rdy_i at cycle 0 on an idle block pops at cycle 1; tx_o falls at cycle 2.
// Backpressure: none upstream; a sample arriving at a full buffer is dropped and flagged on overflow_o.
module sar_sample_uart_tx
    import sar_pkg::*;
#(
    parameter int DATA_W       = SAR_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rdy_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        clr_ovf_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              ovf_q;

    logic              pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    sar_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rdy_i),
        .pop   (pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .level (fifo_level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, counter and shift logic; tx_d is derived from the next state so tx_o is a pure register.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    baud_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // TX state, counters, shift register and registered line output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (rdy_i && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != TX_IDLE);
    assign overflow_o = ovf_q;

endmodule

// File: doc/sar_sample_uart_tx.md
Name: sar_sample_uart_tx

Overview:
Consumer end of the SAR converter's result interface. It captures each completed 8-bit conversion, presented with a one-cycle ready pulse, into a small FIFO. It then serialises the samples out as 8N1 UART frames on a single pin. It sits between the SAR controller outputs (ready strobe and result bus) and a top-level dedicated output pin, so conversions can be streamed off-chip.

Parameters:
DATA_W, 8, sample width in bits; equals the UART data bits per frame.
FIFO_DEPTH, 4, sample buffer entries; must be a power of 2 and at least 2.
CLKS_PER_BIT, 16, clk_i cycles per UART bit; must be at least 2.

Ports:
clk_i  in  1  single clock; all state changes on the rising edge.
rst_i  in  1  reset, synchronous and active-high.
rdy_i  in  1  one-cycle conversion-done strobe from the SAR controller.
data_i  in  DATA_W  conversion result; valid only in a cycle where rdy_i=1.
clr_ovf_i  in  1  clears the sticky overflow flag.
tx_o  out  1  UART serial output; idles high.
busy_o  out  1  high while a frame is in progress (TX state is not IDLE).
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  number of buffered samples, 0..FIFO_DEPTH.
overflow_o  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0.
  - FIFO pointers cleared; TX FSM goes to IDLE.
  - Reset mid-frame aborts the frame: tx_o=1 from the next cycle and buffered samples are discarded.
  - rdy_i is ignored while rst_i=1.
- Capture (push):
  - A sample is pushed when rdy_i=1 and either the FIFO is not full or a pop occurs in the same cycle.
  - A push into a full FIFO with no same-cycle pop drops data_i and sets overflow_o.
  - Push and pop in the same cycle leave fifo_level_o unchanged.
- Overflow flag:
  - overflow_o stays set until clr_ovf_i=1.
  - If a set and a clear occur in the same cycle, the set wins.
- FIFO storage:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level_o is registered and updates one cycle after the push/pop edge.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_level_o != 0, pop the head into the shift register and go to START. Otherwise stay in IDLE with tx_o=1.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift register bit 0 (LSB first), held for CLKS_PER_BIT cycles per bit. After DATA_W bits, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
  - Bit counter is $clog2(DATA_W) bits wide.
- Timing:
  - Latency: rdy_i at cycle 0 with the FIFO empty and TX idle → pop at cycle 1 → tx_o falls at cycle 2.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between the STOP bit and the next START bit, giving a period of (DATA_W+2)*CLKS_PER_BIT+1 cycles.
- Output registration: tx_o is driven from a register, so there is no combinational path from any input to tx_o.

Decomposition:
- Shared package sar_pkg holds:
  - the TX state enum (IDLE, START, DATA, STOP);
  - the SAR_DATA_W=8 constant shared with the SAR controller.
- One sub-module, sar_sample_fifo, provides:
  - synchronous FIFO with push, pop, din, dout, level, full, empty;
  - parameters DATA_W and FIFO_DEPTH;
  - the same clk_i / rst_i conventions as this block.
- The TX FSM, counters and overflow logic live in the top block.

Test Plan:
(All scenarios use CLKS_PER_BIT=4.)
1. Single sample: one rdy_i pulse with data_i=0xA5 on an idle block → tx_o falls at cycle 2; tx_o bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop bit high; busy_o high for 40 cycles; fifo_level_o goes 1 then 0.
2. Burst overflow: 6 back-to-back rdy_i pulses with data 0x01..0x06 → 0x01..0x05 transmitted in order; 0x06 dropped; overflow_o=1 from cycle 6; fifo_level_o peaks at 4.
3. Flag race and clear: rdy_i on a full FIFO in the same cycle as clr_ovf_i=1 → overflow_o remains 1; a later clr_ovf_i alone clears it to 0.
4. Push during pop: fill the FIFO to 4 while TX is busy, then pulse rdy_i in the IDLE pop cycle → sample accepted, fifo_level_o stays 4, overflow_o stays 0.
5. Back-to-back frames: 2 queued samples → the second falling START edge occurs exactly 41 cycles after the first.
6. Mid-frame reset: assert rst_i during DATA bit 3 with 2 samples queued → next cycle tx_o=1, busy_o=0, fifo_level_o=0, overflow_o=0; no further frames are sent.
